// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the fetch PC, drives a synchronous
//            instruction memory (one-cycle read latency), presents ir/pc1/flush
//            to the decoder, skids one pending instruction across stalls and
//            discards wrong-path instructions on an execute redirect.
// Ports    : clk, rst_n          - clock, async active-low reset
//            stall               - decoder cannot accept a new instruction
//            redirect_valid/pc   - taken control transfer resolved in execute
//            imem_addr/imem_rdata- synchronous instruction memory port
//            ir, pc1, flush      - decoder interface
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc1,
  output logic        flush
);

  logic [31:0] fpc;
  logic        valid;    // imem_rdata this cycle is the word for pc1
  logic        held;     // the word for pc1 sits in ir_hold
  logic [31:0] ir_hold;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_addr = fpc;
  assign ir        = held ? ir_hold : (valid ? imem_rdata : NOP_INSN);
  assign flush     = redirect_valid | stall | ~(held | valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc     <= RESET_PC;
      pc1     <= RESET_PC;
      valid   <= 1'b0;
      held    <= 1'b0;
      ir_hold <= NOP_INSN;
    end else if (redirect_valid) begin
      // Both the pending and the in-flight fetch are wrong-path: drop them.
      fpc   <= {redirect_pc[31:2], 2'b00};
      valid <= 1'b0;
      held  <= 1'b0;
    end else if (stall) begin
      // Capture the pending word before memory moves on to mem[fpc].
      if (valid && !held) begin
        ir_hold <= imem_rdata;
        held    <= 1'b1;
      end
      valid <= 1'b0;
    end else begin
      // fpc was frozen during any stall, so mem[fpc] is already on the
      // memory output next cycle: no refetch penalty on release.
      pc1   <= fpc;
      fpc   <= fpc + 32'd4;
      valid <= 1'b1;
      held  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural synchronous ROM
//            (word k = 32'h0010_0093 + (k<<20)) feeds the DUT; per-cycle
//            expectations come from a hand-derived vector table and are queued
//            when stimulus is driven, then popped and compared mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc1;
  logic        flush;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSN(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir             (ir),
    .pc1            (pc1),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    return 32'h0010_0093 + (k << 20);
  endfunction

  always @(posedge clk) imem_rdata <= rom(imem_addr);

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic [31:0] pc;
    logic        ir_rom;   // 1: ir = rom(pc), 0: ir = NOP
    logic        chk_addr;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input logic st, input logic rv, input logic [31:0] rpc,
                     input logic fl, input logic [31:0] pc, input logic ir_rom,
                     input logic chk_addr, input logic [31:0] addr);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.fl = fl; v.pc = pc;
    v.ir_rom = ir_rom; v.chk_addr = chk_addr; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    stall          = v.st;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    exp_q.push_back(v);
  endtask

  task automatic check_pop(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      cmp({tag, " queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, " flush"}, {31'd0, flush}, {31'd0, e.fl});
    cmp({tag, " pc1"}, pc1, e.pc);
    cmp({tag, " ir"}, ir, e.ir_rom ? rom(e.pc) : NOP);
    if (e.chk_addr) cmp({tag, " imem_addr"}, imem_addr, e.addr);
  endtask

  initial begin
    vec_t idle;
    idle.st = 0; idle.rv = 0; idle.rpc = 0; idle.fl = 1; idle.pc = 0;
    idle.ir_rom = 0; idle.chk_addr = 1; idle.addr = 0;

    // Stream: cycles 1..8 -> pc1 0..28
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 0, 32'(4*k), 1, 1, 32'(4*k+4));
    add(0, 1, 32'h8, 1, 32'h20, 1, 0, 0);        // redirect to 8 (setup)
    add(0, 0, 0, 1, 32'h20, 0, 1, 32'h8);
    add(1, 0, 0, 1, 32'h8, 1, 1, 32'hC);         // stall x3 at pc1=8
    add(1, 0, 0, 1, 32'h8, 1, 1, 32'hC);
    add(1, 0, 0, 1, 32'h8, 1, 1, 32'hC);
    add(0, 0, 0, 0, 32'h8, 1, 1, 32'hC);         // release
    add(0, 0, 0, 0, 32'hC, 1, 0, 0);
    add(0, 1, 32'h40, 1, 32'h10, 1, 0, 0);       // redirect 0x40 at pc1=16
    add(0, 0, 0, 1, 32'h10, 0, 1, 32'h40);
    add(0, 0, 0, 0, 32'h40, 1, 1, 32'h44);
    add(0, 1, 32'h43, 1, 32'h44, 1, 0, 0);       // unaligned target
    add(0, 0, 0, 1, 32'h44, 0, 1, 32'h40);
    add(0, 0, 0, 0, 32'h40, 1, 0, 0);
    add(1, 0, 0, 1, 32'h44, 1, 0, 0);            // stall then redirect+stall
    add(1, 1, 32'h80, 1, 32'h44, 1, 0, 0);
    add(0, 0, 0, 1, 32'h44, 0, 1, 32'h80);
    add(0, 0, 0, 0, 32'h80, 1, 0, 0);
    add(0, 1, 32'hFFFF_FFFC, 1, 32'h84, 1, 0, 0); // wrap
    add(0, 0, 0, 1, 32'h84, 0, 1, 32'hFFFF_FFFC);
    add(0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 32'h0);
    add(0, 0, 0, 0, 32'h0, 1, 1, 32'h4);
    add(0, 1, 32'h100, 1, 32'h4, 1, 0, 0);       // stall during bubble
    add(1, 0, 0, 1, 32'h4, 0, 0, 0);
    add(1, 0, 0, 1, 32'h4, 0, 0, 0);
    add(0, 0, 0, 1, 32'h4, 0, 1, 32'h100);
    add(0, 0, 0, 0, 32'h100, 1, 0, 0);
    add(0, 1, 32'h200, 1, 32'h104, 1, 0, 0);     // back-to-back redirects
    add(0, 1, 32'h300, 1, 32'h104, 0, 1, 32'h200);
    add(0, 0, 0, 1, 32'h104, 0, 1, 32'h300);
    add(0, 0, 0, 0, 32'h300, 1, 1, 32'h304);

    // Reset state while held in reset
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_pop("reset");

    // Cycle 0 after release
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(idle);
    @(negedge clk);
    check_pop("cycle0");

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check_pop($sformatf("vec%0d", i));
    end

    // Async reset while an instruction is held in the skid register
    @(posedge clk); #1;
    drive('{st:1, rv:0, rpc:0, fl:1, pc:32'h304, ir_rom:1, chk_addr:1, addr:32'h308});
    @(negedge clk);
    check_pop("pre_hold");
    @(posedge clk); #1;
    drive('{st:1, rv:0, rpc:0, fl:1, pc:32'h304, ir_rom:1, chk_addr:1, addr:32'h308});
    @(negedge clk);
    check_pop("held");
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(idle);
    check_pop("async_rst");
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(idle);
    @(negedge clk);
    check_pop("rst2_cycle0");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      drive('{st:0, rv:0, rpc:0, fl:0, pc:32'(4*k), ir_rom:1, chk_addr:1, addr:32'(4*k+4)});
      @(negedge clk);
      check_pop($sformatf("restart%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
